// File: rtl/tsip_pkg.sv
// Shared constants for the TSIP receive path.
// Contents: DLE/ETX framing bytes, deframer FSM state encoding,
// 8F-AB timing packet field offsets, common TSIP packet IDs and the
// decoded time-of-day payload struct.
package tsip_pkg;

    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_START    = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DLE_SEEN = 2'd3;

    // Payload offsets (byte 0 = first byte after the ID) in the 8F-AB packet
    localparam int unsigned TIM_OFS_SUB    = 0;
    localparam int unsigned TIM_OFS_SEC    = 10;
    localparam int unsigned TIM_OFS_MIN    = 11;
    localparam int unsigned TIM_OFS_HOUR   = 12;
    localparam int unsigned TIM_OFS_DAY    = 13;
    localparam int unsigned TIM_OFS_MONTH  = 14;
    localparam int unsigned TIM_OFS_YEAR_H = 15;
    localparam int unsigned TIM_OFS_YEAR_L = 16;

    localparam logic [7:0] ID_8E = 8'h8E;
    localparam logic [7:0] ID_8F = 8'h8F;
    localparam logic [7:0] ID_A2 = 8'hA2;
    localparam logic [7:0] ID_A5 = 8'hA5;
    localparam logic [7:0] ID_AB = 8'hAB;

    typedef struct packed {
        logic [7:0] year_h;
        logic [7:0] year_l;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minutes;
        logic [7:0] seconds;
    } tim_fields_t;

endpackage

// File: rtl/tsip_rx_framer_if.sv
// Byte-stream input and packet-buffer handshake/read bus of the TSIP deframer.
// slave : deframer side (consumes rx bytes, presents packets)
// master: source/consumer side (uart_rx byte stream and packet reader)
interface tsip_rx_framer_if;
    logic       i_rx_dv;
    logic [7:0] i_rx_byte;
    logic       o_pkt_valid;
    logic       i_pkt_ack;
    logic [7:0] o_pkt_id;
    logic [7:0] o_pkt_len;
    logic [7:0] i_rd_addr;
    logic [7:0] o_rd_data;

    modport slave (
        input  i_rx_dv, i_rx_byte, i_pkt_ack, i_rd_addr,
        output o_pkt_valid, o_pkt_id, o_pkt_len, o_rd_data
    );

    modport master (
        output i_rx_dv, i_rx_byte, i_pkt_ack, i_rd_addr,
        input  o_pkt_valid, o_pkt_id, o_pkt_len, o_rd_data
    );
endinterface

// File: rtl/tsip_pkt_buf.sv
// Two-bank packet buffer: one bank is written by the deframer while the other
// is presented on the registered read port; i_swap exchanges the roles.
// Ports: i_clk, i_rst (sync, active-high), i_wr_en/i_wr_addr/i_wr_data (assembly
// write), i_swap (present assembled bank), i_rd_addr -> o_rd_data (1-cycle latency).
module tsip_pkt_buf #(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_swap,
    input  logic [7:0] i_rd_addr,
    output logic [7:0] o_rd_data
);
    localparam int unsigned AW = $clog2(MAX_LEN);

    logic [7:0] mem [2][MAX_LEN];
    logic       wr_bank;

    // Assembly bank select; the presented bank is always the other one
    always_ff @(posedge i_clk) begin
        if (i_rst) wr_bank <= 1'b0;
        else if (i_swap) wr_bank <= ~wr_bank;
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[wr_bank][AW'(i_wr_addr)] <= i_wr_data;
    end

    // Out-of-range reads return 0 rather than aliasing into the bank
    always_ff @(posedge i_clk) begin
        if (i_rst) o_rd_data <= 8'h00;
        else if (i_rd_addr < 8'(MAX_LEN)) o_rd_data <= mem[~wr_bank][AW'(i_rd_addr)];
        else o_rd_data <= 8'h00;
    end
endmodule

// File: rtl/tsip_rx_framer.sv
// TSIP receive deframer: DLE/ETX framing, byte destuffing, length/framing error
// detection, double-buffered packet presentation with valid/ack, and decode of
// the 8F-AB timing packet into UTC time-of-day fields.
// Ports: i_clk, i_rst (sync, active-high); bus (slave): rx byte strobe in,
// packet valid/ack/id/len and buffer read port out; o_tim_* time fields with
// o_tim_dv update pulse; o_err_frame / o_err_len error pulses; o_drop_cnt.
// Optional: define TSIP_RX_TIMEOUT_EN to abort packets idle for TIMEOUT_CLKS.
module tsip_rx_framer
    import tsip_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 32,
    parameter logic [7:0]  TIM_ID       = ID_8F,
    parameter logic [7:0]  TIM_SUB      = ID_AB,
    parameter int unsigned TIM_LEN      = 17,
    parameter int unsigned TIMEOUT_CLKS = 20000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    tsip_rx_framer_if.slave   bus,
    output logic              o_tim_dv,
    output logic [7:0]        o_tim_year_h,
    output logic [7:0]        o_tim_year_l,
    output logic [7:0]        o_tim_month,
    output logic [7:0]        o_tim_day,
    output logic [7:0]        o_tim_hour,
    output logic [7:0]        o_tim_minutes,
    output logic [7:0]        o_tim_seconds,
    output logic              o_err_frame,
    output logic              o_err_len,
    output logic [7:0]        o_drop_cnt
);
    logic [1:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d, id_q, id_d;
    logic        store_c, wr_en_c, complete_c, err_frame_c, err_len_c, timeout_c;
    logic [7:0]  store_byte_c;
    logic        present_c, drop_c, tim_hit_c;
    logic        pkt_valid_q;
    logic [7:0]  pkt_id_q, pkt_len_q, sub_q;
    tim_fields_t shadow_q, tim_q;

`ifdef TSIP_RX_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    // Idle-clock counter, cleared by any received byte or while idle
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_rx_dv || state_q == ST_IDLE) to_cnt_q <= 32'd0;
        else to_cnt_q <= to_cnt_q + 32'd1;
    end
    assign timeout_c = (state_q != ST_IDLE) && !bus.i_rx_dv &&
                       (to_cnt_q == 32'(TIMEOUT_CLKS - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CLKS);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            id_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
        end
    end

    // Deframer next-state; a DLE seen in DATA is resolved by the following byte
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        id_d         = id_q;
        store_c      = 1'b0;
        store_byte_c = bus.i_rx_byte;
        complete_c   = 1'b0;
        err_frame_c  = 1'b0;
        err_len_c    = 1'b0;
        wr_en_c      = 1'b0;
        if (bus.i_rx_dv) begin
            case (state_q)
                ST_IDLE: if (bus.i_rx_byte == DLE) state_d = ST_START;
                ST_START: begin
                    if (bus.i_rx_byte == DLE || bus.i_rx_byte == ETX) begin
                        state_d = ST_IDLE;
                    end else begin
                        id_d    = bus.i_rx_byte;
                        idx_d   = 8'd0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.i_rx_byte == DLE) state_d = ST_DLE_SEEN;
                    else store_c = 1'b1;
                end
                ST_DLE_SEEN: begin
                    if (bus.i_rx_byte == DLE) begin
                        store_c      = 1'b1;
                        store_byte_c = DLE;
                        state_d      = ST_DATA;
                    end else if (bus.i_rx_byte == ETX) begin
                        complete_c = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Unstuffed DLE followed by a data byte: resync on it as a new ID
                        err_frame_c = 1'b1;
                        id_d        = bus.i_rx_byte;
                        idx_d       = 8'd0;
                        state_d     = ST_DATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_c) begin
            err_frame_c = 1'b1;
            state_d     = ST_IDLE;
        end
        if (store_c) begin
            if (idx_q == 8'(MAX_LEN)) begin
                err_len_c = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                wr_en_c = 1'b1;
                idx_d   = idx_q + 8'd1;
            end
        end
    end

    // Present when the buffer is free or being released this same cycle
    assign present_c = complete_c && (!pkt_valid_q || bus.i_pkt_ack);
    assign drop_c    = complete_c && !present_c;
    assign tim_hit_c = complete_c && (id_q == TIM_ID) && (sub_q == TIM_SUB) &&
                       (idx_q == 8'(TIM_LEN));

    // Timing fields snooped on write so decode is independent of buffer drops
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sub_q    <= 8'd0;
            shadow_q <= '0;
        end else if (wr_en_c) begin
            case (idx_q)
                8'(TIM_OFS_SUB):    sub_q           <= store_byte_c;
                8'(TIM_OFS_SEC):    shadow_q.seconds <= store_byte_c;
                8'(TIM_OFS_MIN):    shadow_q.minutes <= store_byte_c;
                8'(TIM_OFS_HOUR):   shadow_q.hour    <= store_byte_c;
                8'(TIM_OFS_DAY):    shadow_q.day     <= store_byte_c;
                8'(TIM_OFS_MONTH):  shadow_q.month   <= store_byte_c;
                8'(TIM_OFS_YEAR_H): shadow_q.year_h  <= store_byte_c;
                8'(TIM_OFS_YEAR_L): shadow_q.year_l  <= store_byte_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_valid_q <= 1'b0;
            pkt_id_q    <= 8'd0;
            pkt_len_q   <= 8'd0;
            o_drop_cnt  <= 8'd0;
            o_err_frame <= 1'b0;
            o_err_len   <= 1'b0;
            o_tim_dv    <= 1'b0;
            tim_q       <= '0;
        end else begin
            o_err_frame <= err_frame_c;
            o_err_len   <= err_len_c;
            o_tim_dv    <= tim_hit_c;
            if (present_c) begin
                pkt_valid_q <= 1'b1;
                pkt_id_q    <= id_q;
                pkt_len_q   <= idx_q;
            end else if (bus.i_pkt_ack) begin
                pkt_valid_q <= 1'b0;
            end
            if (drop_c && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
            if (tim_hit_c) tim_q <= shadow_q;
        end
    end

    assign bus.o_pkt_valid = pkt_valid_q;
    assign bus.o_pkt_id    = pkt_id_q;
    assign bus.o_pkt_len   = pkt_len_q;
    assign o_tim_year_h    = tim_q.year_h;
    assign o_tim_year_l    = tim_q.year_l;
    assign o_tim_month     = tim_q.month;
    assign o_tim_day       = tim_q.day;
    assign o_tim_hour      = tim_q.hour;
    assign o_tim_minutes   = tim_q.minutes;
    assign o_tim_seconds   = tim_q.seconds;

    tsip_pkt_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (wr_en_c),
        .i_wr_addr (idx_q),
        .i_wr_data (store_byte_c),
        .i_swap    (present_c),
        .i_rd_addr (bus.i_rd_addr),
        .o_rd_data (bus.o_rd_data)
    );
endmodule

// File: tb/tb_tsip_rx_framer.sv
// Directed testbench for tsip_rx_framer: u0 uses default parameters, u1 uses
// MAX_LEN=4 for length-limit cases. Both share clock and reset.
module tb_tsip_rx_framer;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    tsip_rx_framer_if b0();
    tsip_rx_framer_if b1();

    logic       tdv0, ferr0, lerr0;
    logic [7:0] yh0, yl0, mon0, day0, hr0, min0, sec0, drop0;
    logic       tdv1, ferr1, lerr1;
    logic [7:0] f1 [7];
    logic [7:0] drop1;

    int n_ferr0 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ferr0 === 1'b1) n_ferr0 <= n_ferr0 + 1;

    tsip_rx_framer #(.TIMEOUT_CLKS(50)) u0 (
        .i_clk(clk), .i_rst(rst), .bus(b0.slave),
        .o_tim_dv(tdv0), .o_tim_year_h(yh0), .o_tim_year_l(yl0), .o_tim_month(mon0),
        .o_tim_day(day0), .o_tim_hour(hr0), .o_tim_minutes(min0), .o_tim_seconds(sec0),
        .o_err_frame(ferr0), .o_err_len(lerr0), .o_drop_cnt(drop0)
    );

    tsip_rx_framer #(.MAX_LEN(4), .TIMEOUT_CLKS(50)) u1 (
        .i_clk(clk), .i_rst(rst), .bus(b1.slave),
        .o_tim_dv(tdv1), .o_tim_year_h(f1[0]), .o_tim_year_l(f1[1]), .o_tim_month(f1[2]),
        .o_tim_day(f1[3]), .o_tim_hour(f1[4]), .o_tim_minutes(f1[5]), .o_tim_seconds(f1[6]),
        .o_err_frame(ferr1), .o_err_len(lerr1), .o_drop_cnt(drop1)
    );

    task automatic send0(input logic [7:0] b, input logic ack = 1'b0);
        @(negedge clk);
        b0.i_rx_dv = 1'b1; b0.i_rx_byte = b; b0.i_pkt_ack = ack;
        @(negedge clk);
        b0.i_rx_dv = 1'b0; b0.i_pkt_ack = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk);
        b1.i_rx_dv = 1'b1; b1.i_rx_byte = b;
        @(negedge clk);
        b1.i_rx_dv = 1'b0;
    endtask

    task automatic read0(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        b0.i_rd_addr = a;
        @(negedge clk);
        d = b0.o_rd_data;
    endtask

    task automatic ack0();
        @(negedge clk); b0.i_pkt_ack = 1'b1;
        @(negedge clk); b0.i_pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, drop0, tdv0, ferr0, lerr0} !== 27'd0)
            $display("FAIL reset_ctrl got %h required 0",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, drop0, tdv0, ferr0, lerr0});
        else n_pass++;
        n_chk++;
        if ({yh0, yl0, mon0, day0, hr0, min0, sec0, b0.o_rd_data} !== 64'd0)
            $display("FAIL reset_fields got %h required 0",
                     {yh0, yl0, mon0, day0, hr0, min0, sec0, b0.o_rd_data});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timing();
        logic [7:0] d;
        send0(8'h10); send0(8'h8F); send0(8'hAB);
        for (int i = 1; i <= 9; i++) send0(8'(i));
        send0(8'h1E); send0(8'h2D); send0(8'h0C); send0(8'h07);
        send0(8'h03); send0(8'h07); send0(8'hE8);
        send0(8'h10); send0(8'h03);
        n_chk++;
        if (tdv0 !== 1'b1) $display("FAIL tim_dv got %b required 1", tdv0); else n_pass++;
        n_chk++;
        if ({sec0, min0, hr0, day0, mon0, yh0, yl0} !== 56'h1E2D0C070307E8)
            $display("FAIL tim_fields got %h required 1e2d0c070307e8",
                     {sec0, min0, hr0, day0, mon0, yh0, yl0});
        else n_pass++;
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len} !== {1'b1, 8'h8F, 8'd17})
            $display("FAIL tim_pkt got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len}, {1'b1, 8'h8F, 8'd17});
        else n_pass++;
        read0(8'd0, d);
        n_chk++;
        if (d !== 8'hAB) $display("FAIL rd0 got %h required ab", d); else n_pass++;
        n_chk++;
        if (tdv0 !== 1'b0) $display("FAIL tim_dv_pulse got %b required 0", tdv0); else n_pass++;
        read0(8'd16, d);
        n_chk++;
        if (d !== 8'hE8) $display("FAIL rd16 got %h required e8", d); else n_pass++;
        ack0();
        n_chk++;
        if (b0.o_pkt_valid !== 1'b0) $display("FAIL ack_clear got %b required 0", b0.o_pkt_valid);
        else n_pass++;
    endtask

    task automatic test_stuffing();
        logic [7:0] d;
        send0(8'h10); send0(8'h8F); send0(8'hAB);
        for (int i = 1; i <= 9; i++) send0(8'(i));
        send0(8'h10); send0(8'h10);
        send0(8'h2D); send0(8'h0C); send0(8'h07); send0(8'h03); send0(8'h07); send0(8'hE8);
        send0(8'h10); send0(8'h03);
        n_chk++;
        if ({tdv0, sec0, min0, b0.o_pkt_len} !== {1'b1, 8'h10, 8'h2D, 8'd17})
            $display("FAIL stuff_tim got %h required %h",
                     {tdv0, sec0, min0, b0.o_pkt_len}, {1'b1, 8'h10, 8'h2D, 8'd17});
        else n_pass++;
        read0(8'd10, d);
        n_chk++;
        if (d !== 8'h10) $display("FAIL stuff_rd10 got %h required 10", d); else n_pass++;
        read0(8'd11, d);
        n_chk++;
        if (d !== 8'h2D) $display("FAIL stuff_rd11 got %h required 2d", d); else n_pass++;
        ack0();
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        send0(8'h10); send0(8'h8F); send0(8'h01); send0(8'h10); send0(8'h55);
        n_chk++;
        if (ferr0 !== 1'b1) $display("FAIL frame_err got %b required 1", ferr0); else n_pass++;
        send0(8'h22); send0(8'h10); send0(8'h03);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, tdv0} !== {1'b1, 8'h55, 8'd1, 1'b0})
            $display("FAIL resync_pkt got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, tdv0}, {1'b1, 8'h55, 8'd1, 1'b0});
        else n_pass++;
        read0(8'd0, d);
        n_chk++;
        if (d !== 8'h22) $display("FAIL resync_rd got %h required 22", d); else n_pass++;
        ack0();
    endtask

    task automatic test_zero_len_and_mismatch();
        send0(8'h10); send0(8'hA2); send0(8'h10); send0(8'h03);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len} !== {1'b1, 8'hA2, 8'd0})
            $display("FAIL zero_len got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len}, {1'b1, 8'hA2, 8'd0});
        else n_pass++;
        ack0();
        // 8F-AB with only 16 payload bytes: buffered but not decoded
        send0(8'h10); send0(8'h8F); send0(8'hAB);
        for (int i = 1; i <= 15; i++) send0(8'h40 + 8'(i));
        send0(8'h10); send0(8'h03);
        n_chk++;
        if ({tdv0, sec0, b0.o_pkt_valid, b0.o_pkt_len, lerr0, ferr0} !== {1'b0, 8'h10, 1'b1, 8'd16, 2'b00})
            $display("FAIL len_mismatch got %h required %h",
                     {tdv0, sec0, b0.o_pkt_valid, b0.o_pkt_len, lerr0, ferr0},
                     {1'b0, 8'h10, 1'b1, 8'd16, 2'b00});
        else n_pass++;
        ack0();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        send0(8'h10); send0(8'h8E); send0(8'h11); send0(8'h10); send0(8'h03);
        send0(8'h10); send0(8'hA5); send0(8'h22); send0(8'h33); send0(8'h10); send0(8'h03);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, drop0} !== {1'b1, 8'h8E, 8'd1, 8'd1})
            $display("FAIL drop got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len, drop0}, {1'b1, 8'h8E, 8'd1, 8'd1});
        else n_pass++;
        read0(8'd0, d);
        n_chk++;
        if (d !== 8'h11) $display("FAIL drop_rd got %h required 11", d); else n_pass++;
        send0(8'h10); send0(8'hAB); send0(8'h44); send0(8'h10); send0(8'h03, 1'b1);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, drop0} !== {1'b1, 8'hAB, 8'd1})
            $display("FAIL ack_complete got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, drop0}, {1'b1, 8'hAB, 8'd1});
        else n_pass++;
        read0(8'd0, d);
        n_chk++;
        if (d !== 8'h44) $display("FAIL ack_complete_rd got %h required 44", d); else n_pass++;
        ack0();
        n_chk++;
        if (b0.o_pkt_valid !== 1'b0) $display("FAIL final_ack got %b required 0", b0.o_pkt_valid);
        else n_pass++;
    endtask

    task automatic test_len_err();
        send1(8'h10); send1(8'h8E);
        for (int i = 1; i <= 4; i++) send1(8'(i));
        send1(8'h10); send1(8'h03);
        n_chk++;
        if ({b1.o_pkt_valid, b1.o_pkt_len} !== {1'b1, 8'd4})
            $display("FAIL len_max got %h required %h", {b1.o_pkt_valid, b1.o_pkt_len}, {1'b1, 8'd4});
        else n_pass++;
        @(negedge clk); b1.i_pkt_ack = 1'b1;
        @(negedge clk); b1.i_pkt_ack = 1'b0;
        send1(8'h10); send1(8'h8E);
        for (int i = 1; i <= 5; i++) send1(8'(i));
        n_chk++;
        if (lerr1 !== 1'b1) $display("FAIL len_err got %b required 1", lerr1); else n_pass++;
        send1(8'h06); send1(8'h10); send1(8'h03);
        n_chk++;
        if ({b1.o_pkt_valid, ferr1} !== 2'b00)
            $display("FAIL len_err_novalid got %b required 00", {b1.o_pkt_valid, ferr1});
        else n_pass++;
    endtask

`ifdef TSIP_RX_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        base = n_ferr0;
        send0(8'h10); send0(8'h8F); send0(8'h01);
        repeat (60) @(negedge clk);
        n_chk++;
        if (n_ferr0 - base !== 1) $display("FAIL timeout_err got %0d required 1", n_ferr0 - base);
        else n_pass++;
        send0(8'h10); send0(8'hA5); send0(8'h07); send0(8'h10); send0(8'h03);
        n_chk++;
        if ({b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len} !== {1'b1, 8'hA5, 8'd1})
            $display("FAIL timeout_recover got %h required %h",
                     {b0.o_pkt_valid, b0.o_pkt_id, b0.o_pkt_len}, {1'b1, 8'hA5, 8'd1});
        else n_pass++;
        ack0();
    endtask
`endif

    initial begin
        b0.i_rx_dv = 1'b0; b0.i_rx_byte = 8'h00; b0.i_pkt_ack = 1'b0; b0.i_rd_addr = 8'h00;
        b1.i_rx_dv = 1'b0; b1.i_rx_byte = 8'h00; b1.i_pkt_ack = 1'b0; b1.i_rd_addr = 8'h00;
        test_reset();
        test_timing();
        test_stuffing();
        test_frame_err();
        test_zero_len_and_mismatch();
        test_back_to_back();
        test_len_err();
`ifdef TSIP_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1);
    end
endmodule

// File: doc/tsip_rx_framer.md
Name: tsip_rx_framer

Overview:
- Parametrised TSIP receive deframer; sits between uart_rx (byte stream) and the time-of-day register map / pulse generators.
- Full DLE/ETX framing with byte-destuffing, length and framing error detection, generic packet buffer with read port and valid/ack handshake.
- Built-in decode of the 8F-AB timing packet into UTC time-of-day fields; replaces ad hoc subcode-matching receive logic.

Parameters:
MAX_LEN, 32, max destuffed payload bytes after the ID byte (buffer depth); 4..255
TIM_ID, 8'h8F, packet ID decoded as timing packet
TIM_SUB, 8'hAB, subcode (payload byte 0) decoded as timing packet
TIM_LEN, 17, exact payload length required for timing decode
TIMEOUT_CLKS, 20000, idle clocks mid-packet before abort (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_rx_dv  in  1  one-cycle strobe, byte valid from uart_rx
i_rx_byte  in  8  received byte
o_pkt_valid  out  1  level; buffered packet available
i_pkt_ack  in  1  consumer releases buffer
o_pkt_id  out  8  ID of buffered packet
o_pkt_len  out  8  destuffed payload length of buffered packet
i_rd_addr  in  8  buffer read address
o_rd_data  out  8  buffer byte at i_rd_addr, registered, 1-cycle latency
o_tim_dv  out  1  one-cycle pulse, time fields updated
o_tim_year_h, o_tim_year_l, o_tim_month, o_tim_day, o_tim_hour, o_tim_minutes, o_tim_seconds  out  8 each  UTC time fields
o_err_frame  out  1  one-cycle pulse: illegal DLE sequence
o_err_len  out  1  one-cycle pulse: payload exceeded MAX_LEN
o_drop_cnt  out  8  saturating count of completed packets dropped while o_pkt_valid high

Behaviour:
- Reset: state IDLE, all outputs 0, write index 0. Reset mid-packet discards it.
- Bytes processed only on i_rx_dv; all other cycles hold state.
- FSM:
  IDLE: DLE -> START; else stay.
  START: DLE or ETX -> IDLE (tail of previous frame / stuffed byte); other -> latch ID, idx=0, -> DATA.
  DATA: DLE -> DLE_SEEN; else store byte at idx, idx++.
  DLE_SEEN: DLE -> store one 8'h10, idx++, -> DATA; ETX -> complete, -> IDLE; other -> o_err_frame pulse, treat byte as new ID, idx=0, -> DATA.
- Store when idx==MAX_LEN: o_err_len pulse, -> IDLE.
- Double buffering: assembly buffer separate from presented buffer. On complete: if o_pkt_valid=0, copy/swap into presented buffer, o_pkt_valid=1 next cycle with o_pkt_id/o_pkt_len; if o_pkt_valid=1, drop, o_drop_cnt++ (saturate at 255).
- i_pkt_ack while o_pkt_valid=1: o_pkt_valid=0 next cycle. Complete and ack same cycle: new packet presented (valid stays 1), no drop.
- Timing decode at complete, independent of handshake and drops: ID==TIM_ID, byte0==TIM_SUB, len==TIM_LEN -> next cycle o_tim_dv=1, seconds=byte10, minutes=11, hour=12, day=13, month=14, year_h=15, year_l=16. Mismatched length: no update, no error.
- Zero-length packet (DLE ID DLE ETX) valid, o_pkt_len=0.
- Latency: last ETX strobe to o_pkt_valid / o_tim_dv = 1 clock.

Optional Feature:
- Macro TSIP_RX_TIMEOUT_EN. Defined: counter clears on every i_rx_dv, counts while FSM not IDLE; at TIMEOUT_CLKS -> abort to IDLE, o_err_frame pulse. Undefined: no counter; partial packet waits indefinitely.

Decomposition:
- Package tsip_pkg: DLE/ETX constants, FSM state encoding, 8F-AB field offsets, TSIP IDs (8E, 8F, A2, A5, AB).
- Sub-module tsip_pkt_buf: two MAX_LEN x 8 banks, write port, registered read port, bank-swap control.

Test Plan:
- 10 8F AB + 16 bytes (byte10=0x1E, 11=0x2D, 12=0x0C, 13=0x07, 14=0x03, 15=0x07, 16=0xE8) 10 03 -> o_tim_dv pulse, seconds=30, minutes=45, hour=12, day=7, month=3, year=0x07E8; o_pkt_len=17.
- Payload containing 10 10 -> single 0x10 stored, length counts once; timing fields correct when 10 10 lies in byte10.
- 10 8F 01 10 55 -> o_err_frame pulse; new packet ID=0x55 completes on subsequent 10 03.
- MAX_LEN=4, 6 payload bytes -> o_err_len pulse, no o_pkt_valid.
- Two packets without ack -> second dropped, o_drop_cnt=1; ack on same cycle as third completion -> third presented, valid stays 1.
- With TSIP_RX_TIMEOUT_EN, stall mid-packet TIMEOUT_CLKS -> o_err_frame, FSM IDLE; next good frame accepted.
